// File: rtl/sa_pkg.sv
// Shared definitions for the systolic-array edge feeders and PE-side blocks.
// Words are Q2.13 fixed point: 1 sign bit, 2 integer bits, 13 fraction bits.
package sa_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLR   = 2'd1,
    FEED  = 2'd2,
    DRAIN = 2'd3
  } sa_state_e;

  localparam int SA_D_W    = 16;
  localparam int SA_N      = 4;
  localparam int SA_FRAC_W = 13;

endpackage

// File: rtl/sa_skew_line.sv
// DEPTH-stage data+valid shift register; one per lane to build the diagonal skew.
module sa_skew_line #(
  parameter int D_W   = 16,
  parameter int DEPTH = 1
) (
  input  logic           I_CLK,
  input  logic           I_ASYN_RST,
  input  logic [D_W-1:0] I_D,
  input  logic           I_VLD,
  output logic [D_W-1:0] O_D,
  output logic           O_VLD
);

  logic [D_W-1:0]   dat_pipe [DEPTH];
  logic [DEPTH-1:0] vld_pipe;

  always_ff @(posedge I_CLK or posedge I_ASYN_RST) begin
    if (I_ASYN_RST) begin
      for (int s = 0; s < DEPTH; s++) begin
        dat_pipe[s] <= '0;
      end
      vld_pipe <= '0;
    end else begin
      dat_pipe[0] <= I_D;
      vld_pipe[0] <= I_VLD;
      for (int s = 1; s < DEPTH; s++) begin
        dat_pipe[s] <= dat_pipe[s-1];
        vld_pipe[s] <= vld_pipe[s-1];
      end
    end
  end

  assign O_D   = dat_pipe[DEPTH-1];
  assign O_VLD = vld_pipe[DEPTH-1];

endmodule

// File: rtl/sa_skew_feeder.sv
// Edge injector: skews accepted N-word beats across lanes, pulses the PE
// accumulator clear before each matrix and flags completion after drain.
module sa_skew_feeder
  import sa_pkg::*;
#(
  parameter int D_W = SA_D_W,
  parameter int N   = SA_N,
  parameter int K_W = 8
) (
  input  logic           I_CLK,
  input  logic           I_ASYN_RST,
  input  logic           I_START,
  input  logic           I_VLD,
  output logic           O_RDY,
  input  logic [N*D_W-1:0] I_ROW,
  input  logic           I_LAST,
  output logic [N*D_W-1:0] O_X,
  output logic [N-1:0]   O_VLD,
  output logic           O_SA_RSTN,
  output logic           O_BUSY,
  output logic           O_DONE,
  output logic [K_W-1:0] O_BEATS
);

  localparam int CNT_W = $clog2(N);

  sa_state_e        state, state_nxt;
  logic [CNT_W-1:0] drain_cnt;
  logic [K_W-1:0]   beats;
  logic             accept;
  logic             drain_last;

  function automatic logic [K_W-1:0] sat_inc(input logic [K_W-1:0] v);
    return (v == {K_W{1'b1}}) ? v : v + K_W'(1);
  endfunction

  assign accept     = I_VLD && (state == FEED);
  assign drain_last = (drain_cnt == CNT_W'(N-1));

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (I_START) state_nxt = CLR;
      CLR:     state_nxt = FEED;
      FEED:    if (accept && I_LAST) state_nxt = DRAIN;
      DRAIN:   if (drain_last) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge I_CLK or posedge I_ASYN_RST) begin
    if (I_ASYN_RST) begin
      state     <= IDLE;
      drain_cnt <= '0;
      beats     <= '0;
    end else begin
      state <= state_nxt;
      // DRAIN spans N cycles so lane N-1's last word is out when DONE fires
      if (state == DRAIN) drain_cnt <= drain_cnt + CNT_W'(1);
      else                drain_cnt <= '0;
      if (state == IDLE && I_START) beats <= '0;
      else if (accept)              beats <= sat_inc(beats);
    end
  end

  assign O_RDY     = (state == FEED);
  assign O_SA_RSTN = (state != CLR);
  assign O_BUSY    = (state != IDLE);
  assign O_DONE    = (state == DRAIN) && drain_last;
  assign O_BEATS   = beats;

  // lane i: i+1 register stages; non-accepted cycles inject zero bubbles
  for (genvar i = 0; i < N; i++) begin : g_lane
    logic [D_W-1:0] lane_d;
    assign lane_d = accept ? I_ROW[i*D_W +: D_W] : '0;

    sa_skew_line #(
      .D_W  (D_W),
      .DEPTH(i + 1)
    ) u_line (
      .I_CLK     (I_CLK),
      .I_ASYN_RST(I_ASYN_RST),
      .I_D       (lane_d),
      .I_VLD     (accept),
      .O_D       (O_X[i*D_W +: D_W]),
      .O_VLD     (O_VLD[i])
    );
  end

endmodule

// File: tb/tb_sa_skew_feeder.sv
// Scoreboard bench for sa_skew_feeder: lane words, skew timing, clear and done pulses.
module tb_sa_skew_feeder;

  localparam int D_W = 16;
  localparam int N   = 4;

  typedef struct packed {
    logic [15:0] w;
    logic [31:0] c;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             start = 1'b0;
  logic             vld = 1'b0;
  logic             last = 1'b0;
  logic [N*D_W-1:0] row = '0;

  logic             rdy_m, rstn_m, busy_m, done_m;
  logic [N*D_W-1:0] x_m;
  logic [N-1:0]     ov_m;
  logic [7:0]       beats_m;

  logic             rdy_s, rstn_s, busy_s, done_s;
  logic [N*D_W-1:0] x_s;
  logic [N-1:0]     ov_s;
  logic [1:0]       beats_s;

  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  exp_t exp_q [2][N][$];
  logic [31:0] exp_done [$];
  logic [31:0] exp_clr [$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  sa_skew_feeder #(.D_W(D_W), .N(N), .K_W(8)) u_dut (
    .I_CLK(clk), .I_ASYN_RST(rst), .I_START(start), .I_VLD(vld), .O_RDY(rdy_m),
    .I_ROW(row), .I_LAST(last), .O_X(x_m), .O_VLD(ov_m), .O_SA_RSTN(rstn_m),
    .O_BUSY(busy_m), .O_DONE(done_m), .O_BEATS(beats_m)
  );

  sa_skew_feeder #(.D_W(D_W), .N(N), .K_W(2)) u_sat (
    .I_CLK(clk), .I_ASYN_RST(rst), .I_START(start), .I_VLD(vld), .O_RDY(rdy_s),
    .I_ROW(row), .I_LAST(last), .O_X(x_s), .O_VLD(ov_s), .O_SA_RSTN(rstn_s),
    .O_BUSY(busy_s), .O_DONE(done_s), .O_BEATS(beats_s)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor: pops expectations whenever the DUTs present something
  always @(negedge clk) begin : mon
    logic        v;
    logic [15:0] w;
    exp_t        e;
    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < N; i++) begin
        v = (d == 0) ? ov_m[i] : ov_s[i];
        w = (d == 0) ? x_m[i*D_W +: D_W] : x_s[i*D_W +: D_W];
        if (v) begin
          if (exp_q[d][i].size() == 0) begin
            chk($sformatf("unexpected_valid_d%0d_lane%0d", d, i), {16'h0, w}, 64'hdead);
          end else begin
            e = exp_q[d][i].pop_front();
            chk($sformatf("lane_word_d%0d_l%0d", d, i), {48'h0, w}, {48'h0, e.w});
            chk($sformatf("lane_cycle_d%0d_l%0d", d, i), cyc, e.c);
          end
        end else begin
          chk($sformatf("bubble_data_d%0d_l%0d", d, i), w, 0);
        end
      end
    end
    if (done_m) begin
      if (exp_done.size() == 0) chk("unexpected_done", cyc, 32'hffff_ffff);
      else                      chk("done_cycle", cyc, exp_done.pop_front());
    end
    if (!rstn_m) begin
      if (exp_clr.size() == 0) chk("unexpected_clear", cyc, 32'hffff_ffff);
      else                     chk("clear_cycle", cyc, exp_clr.pop_front());
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_mat();
    start = 1'b1;
    tick();
    start = 1'b0;
    exp_clr.push_back(cyc);
    tick();
  endtask

  task automatic beat(input logic [N*D_W-1:0] r, input logic v, input logic l, input logic st);
    exp_t e;
    row = r; vld = v; last = l; start = st;
    tick();
    if (v) begin
      for (int i = 0; i < N; i++) begin
        e.w = r[i*D_W +: D_W];
        e.c = cyc + i;
        exp_q[0][i].push_back(e);
        exp_q[1][i].push_back(e);
      end
      if (l) exp_done.push_back(cyc + N - 1);
    end
    row = '0; vld = 1'b0; last = 1'b0; start = 1'b0;
  endtask

  task automatic drain_check(input logic st);
    for (int k = 0; k < N; k++) begin
      chk("drain_rdy", rdy_m, 0);
      chk("drain_busy", busy_m, 1);
      start = st;
      tick();
    end
    start = 1'b0;
    chk("idle_after_drain", busy_m, 0);
  endtask

  task automatic chk_reset_vals();
    chk("rst_rdy", rdy_m, 0);
    chk("rst_x", x_m, 0);
    chk("rst_vld", ov_m, 0);
    chk("rst_sa_rstn", rstn_m, 1);
    chk("rst_busy", busy_m, 0);
    chk("rst_done", done_m, 0);
    chk("rst_beats", beats_m, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: timeout at cycle %0d", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk_reset_vals();
    rst = 1'b0;
    repeat (2) tick();

    // single beat, lane i carries word i+1
    start_mat();
    beat({16'h0004, 16'h0003, 16'h0002, 16'h0001}, 1'b1, 1'b1, 1'b0);
    drain_check(1'b0);
    chk("single_beats", beats_m, 1);
    repeat (2) tick();

    // three back-to-back beats
    start_mat();
    beat({16'h0013, 16'h0012, 16'h0011, 16'h0010}, 1'b1, 1'b0, 1'b0);
    beat({16'h0023, 16'h0022, 16'h0021, 16'h0020}, 1'b1, 1'b0, 1'b0);
    beat({16'h0033, 16'h0032, 16'h0031, 16'h0030}, 1'b1, 1'b1, 1'b0);
    drain_check(1'b0);
    chk("b2b_beats", beats_m, 3);
    repeat (2) tick();

    // valid gaps 1,0,1; I_LAST on the gap must be ignored
    start_mat();
    beat({16'hA003, 16'hA002, 16'hA001, 16'hA000}, 1'b1, 1'b0, 1'b0);
    beat({16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF}, 1'b0, 1'b1, 1'b0);
    chk("gap_still_feed", rdy_m, 1);
    beat({16'hB003, 16'hB002, 16'hB001, 16'hB000}, 1'b1, 1'b1, 1'b0);
    drain_check(1'b0);
    chk("gap_beats", beats_m, 2);
    repeat (2) tick();

    // I_START held during FEED and DRAIN
    start_mat();
    beat({16'h8000, 16'h7FFF, 16'h2000, 16'hE000}, 1'b1, 1'b0, 1'b1);
    beat({16'h0000, 16'h0000, 16'h0000, 16'h0000}, 1'b0, 1'b0, 1'b1);
    beat({16'h1234, 16'h5678, 16'h9ABC, 16'hDEF0}, 1'b1, 1'b1, 1'b1);
    drain_check(1'b1);
    chk("start_ignored_beats", beats_m, 2);
    repeat (2) tick();

    // saturation: 5 beats, K_W=2 instance sticks at 3
    start_mat();
    beat({16'h0103, 16'h0102, 16'h0101, 16'h0100}, 1'b1, 1'b0, 1'b0);
    beat({16'h0203, 16'h0202, 16'h0201, 16'h0200}, 1'b1, 1'b0, 1'b0);
    beat({16'h0303, 16'h0302, 16'h0301, 16'h0300}, 1'b1, 1'b0, 1'b0);
    beat({16'h0403, 16'h0402, 16'h0401, 16'h0400}, 1'b1, 1'b0, 1'b0);
    beat({16'h0503, 16'h0502, 16'h0501, 16'h0500}, 1'b1, 1'b1, 1'b0);
    drain_check(1'b0);
    chk("sat_beats_k8", beats_m, 5);
    chk("sat_beats_k2", beats_s, 3);
    repeat (2) tick();

    // asynchronous reset after two beats of a matrix
    start_mat();
    beat({16'hC003, 16'hC002, 16'hC001, 16'hC000}, 1'b1, 1'b0, 1'b0);
    beat({16'hD003, 16'hD002, 16'hD001, 16'hD000}, 1'b1, 1'b0, 1'b0);
    #1;
    rst = 1'b1;
    for (int d = 0; d < 2; d++)
      for (int i = 0; i < N; i++) exp_q[d][i].delete();
    #1;
    chk_reset_vals();
    tick();
    rst = 1'b0;
    repeat (N + 4) tick();
    chk("post_abort_busy", busy_m, 0);

    for (int d = 0; d < 2; d++)
      for (int i = 0; i < N; i++) chk($sformatf("leftover_d%0d_l%0d", d, i), exp_q[d][i].size(), 0);
    chk("leftover_done", exp_done.size(), 0);
    chk("leftover_clr", exp_clr.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
